// File: rtl/series_engine.sv
// series_engine: fixed-point power-series evaluator with a per-term ratio coefficient.
//   sum = 1 + sum_{k=1..n} (+/-) p^k * prod(c_1..c_k), with p = x or x^2, all saturating.
// Ports: clk/rst (async active-high); start/abort control; x_in, n_terms and mode are
//   captured in LOAD; coef_addr/coef_data form a combinational coefficient read;
//   ready/busy/done report the state; result and the sticky ovf hold the outcome.
module series_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int TERMS = 8,
    parameter int CW    = $clog2(TERMS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic        [CW-1:0]    n_terms,
    input  logic        [1:0]       mode,
    output logic        [CW-1:0]    coef_addr,
    input  logic signed [WIDTH-1:0] coef_data,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovf
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_LOAD, S_XMUL, S_CMUL, S_ACC, S_DONE
    } state_t;

    localparam logic signed [WIDTH-1:0]   ONE  = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [WIDTH-1:0]   SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    // Both helpers return {saturated, value}.
    function automatic logic [WIDTH:0] mul_sat(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] prod;
        logic signed [2*WIDTH-1:0] sh;
        prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        sh   = prod >>> FRAC;   // arithmetic shift: truncates toward -inf
        if (sh > PMAX)      mul_sat = {1'b1, SMAX};
        else if (sh < PMIN) mul_sat = {1'b1, SMIN};
        else                mul_sat = {1'b0, sh[WIDTH-1:0]};
    endfunction

    function automatic logic [WIDTH:0] add_sat(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b,
                                               input logic                    sub);
        logic signed [WIDTH:0] s;
        if (sub) s = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
        else     s = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        if (s[WIDTH] != s[WIDTH-1]) add_sat = {1'b1, (s[WIDTH] ? SMIN : SMAX)};
        else                        add_sat = {1'b0, s[WIDTH-1:0]};
    endfunction

    state_t                  state, next_state;
    logic signed [WIDTH-1:0] tmp;
    logic signed [WIDTH-1:0] p;
    logic        [CW-1:0]    k;
    logic        [CW-1:0]    n_reg;
    logic                    alt;

    logic        [CW-1:0]    n_clamp;
    logic        [WIDTH:0]   sq, mt, mc, acc;

    assign n_clamp = (n_terms > CW'(TERMS)) ? CW'(TERMS) : n_terms;
    assign sq      = mul_sat(x_in, x_in);
    assign mt      = mul_sat(tmp, p);
    assign mc      = mul_sat(tmp, coef_data);
    // Odd terms are subtracted when the alternating-sign mode was captured.
    assign acc     = add_sat(result, tmp, alt & k[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = S_INIT;
            S_INIT: if (abort) next_state = S_IDLE;
                    else if (!start) next_state = S_LOAD;
            S_LOAD: if (abort) next_state = S_IDLE;
                    else next_state = (n_clamp == '0) ? S_DONE : S_XMUL;
            S_XMUL: next_state = abort ? S_IDLE : S_CMUL;
            S_CMUL: next_state = abort ? S_IDLE : S_ACC;
            S_ACC:  if (abort) next_state = S_IDLE;
                    else next_state = (k == n_reg) ? S_DONE : S_XMUL;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // An aborted cycle makes no datapath update, so partial results stay as they were.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmp    <= '0;
            result <= '0;
            p      <= '0;
            k      <= '0;
            n_reg  <= '0;
            alt    <= 1'b0;
            ovf    <= 1'b0;
        end else if (!abort) begin
            case (state)
                S_INIT: begin
                    tmp    <= ONE;
                    result <= ONE;
                    k      <= CW'(1);
                    ovf    <= 1'b0;
                end
                S_LOAD: begin
                    n_reg <= n_clamp;
                    alt   <= mode[0];
                    p     <= mode[1] ? sq[WIDTH-1:0] : x_in;
                    if (mode[1] && sq[WIDTH]) ovf <= 1'b1;
                end
                S_XMUL: begin
                    tmp <= mt[WIDTH-1:0];
                    if (mt[WIDTH]) ovf <= 1'b1;
                end
                S_CMUL: begin
                    tmp <= mc[WIDTH-1:0];
                    if (mc[WIDTH]) ovf <= 1'b1;
                end
                S_ACC: begin
                    result <= acc[WIDTH-1:0];
                    k      <= k + CW'(1);
                    if (acc[WIDTH]) ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign coef_addr = (state == S_CMUL) ? (k - CW'(1)) : '0;
    assign ready     = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign busy      = (state == S_INIT) || (state == S_LOAD) || (state == S_XMUL) ||
                       (state == S_CMUL) || (state == S_ACC);

endmodule

// File: tb/tb_series_engine.sv
// tb_series_engine: scoreboard bench for series_engine (WIDTH=16, FRAC=8, TERMS=8)
//   with a 1/k coefficient ROM. Expected result/ovf/latency are queued at launch and
//   popped on done; abort and mid-run reset are exercised with direct checks.
module tb_series_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic signed [15:0] x_in;
    logic        [3:0]  n_terms;
    logic        [1:0]  mode;
    logic        [3:0]  coef_addr;
    logic signed [15:0] coef_data;
    logic               ready;
    logic               busy;
    logic               done;
    logic signed [15:0] result;
    logic               ovf;

    logic signed [15:0] rom [0:7];

    typedef struct {
        logic signed [15:0] res;
        logic               o;
        int                 lat;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    series_engine #(.WIDTH(16), .FRAC(8), .TERMS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .x_in(x_in), .n_terms(n_terms), .mode(mode),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .ready(ready), .busy(busy), .done(done), .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    assign coef_data = (coef_addr < 4'd8) ? rom[coef_addr[2:0]] : 16'sd0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic sat16(inout longint v, inout bit o);
        if (v > 32767)       begin v = 32767;  o = 1'b1; end
        else if (v < -32768) begin v = -32768; o = 1'b1; end
    endtask

    // Straight arithmetic model of the series, used for the randomised runs.
    task automatic model(input int x, input int n, input int m, input int hold,
                         output exp_t e);
        longint t, r, pw, v;
        bit     o;
        int     nn;
        nn = (n > 8) ? 8 : n;
        o  = 1'b0;
        t  = 256;
        r  = 256;
        pw = x;
        if ((m & 2) != 0) begin v = (pw * pw) >>> 8; sat16(v, o); pw = v; end
        for (int kk = 1; kk <= nn; kk++) begin
            v = (t * pw) >>> 8;                    sat16(v, o); t = v;
            v = (t * longint'(rom[kk-1])) >>> 8;   sat16(v, o); t = v;
            if (((m & 1) != 0) && ((kk % 2) == 1)) v = r - t;
            else                                   v = r + t;
            sat16(v, o); r = v;
        end
        e.res = r[15:0];
        e.o   = o;
        e.lat = 3 * nn + 2 + hold - 1;
    endtask

    task automatic run(input logic signed [15:0] x, input logic [3:0] n,
                       input logic [1:0] m, input int hold, input exp_t e);
        exp_t got_e;
        int   lat;
        sbq.push_back(e);
        @(negedge clk);
        x_in = x; n_terms = n; mode = m; start = 1'b1;
        @(posedge clk);
        lat = 0;
        repeat (hold - 1) begin @(posedge clk); lat++; end
        #1 start = 1'b0;
        while (!done && lat < 300) begin @(posedge clk); lat++; #1; end
        chk("done_seen", done, 1);
        got_e = sbq.pop_front();
        chk("result", result, got_e.res);
        chk("ovf", ovf, got_e.o);
        chk("latency", lat, got_e.lat);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("ready_after", ready, 1);
    endtask

    // Launch x=256,n=4,mode=00 and stop #1 after entering the second CMUL.
    task automatic launch_to_second_cmul();
        int cnt;
        @(negedge clk);
        x_in = 16'sd256; n_terms = 4'd4; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        while (coef_addr != 4'd1 && cnt < 100) begin @(posedge clk); cnt++; #1; end
        chk("reach_cmul2", (cnt < 100) ? 1 : 0, 1);
    endtask

    initial begin
        exp_t e;
        int   seen;
        rom[0] = 16'sd256; rom[1] = 16'sd128; rom[2] = 16'sd85; rom[3] = 16'sd64;
        rom[4] = 16'sd51;  rom[5] = 16'sd43;  rom[6] = 16'sd37; rom[7] = 16'sd32;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        x_in = '0; n_terms = '0; mode = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_coef_addr", coef_addr, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        e = '{16'sd692, 1'b0, 14};     run(16'sd256, 4'd4, 2'b00, 1, e);
        e = '{16'sd96, 1'b0, 14};      run(16'sd256, 4'd4, 2'b01, 1, e);
        e = '{16'sd256, 1'b0, 2};      run(16'sd256, 4'd0, 2'b00, 1, e);
        model(256, 15, 0, 1, e);       run(16'sd256, 4'd15, 2'b00, 1, e);
        chk("clamp_latency_model", e.lat, 26);
        e = '{16'sh7FFF, 1'b1, 8};     run(16'sh7F00, 4'd2, 2'b10, 1, e);

        // Abort in the second CMUL: back to IDLE, partial result kept, no done.
        launch_to_second_cmul();
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_ready", ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 512);
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (done) seen++; end
        chk("abort_no_done", seen, 0);
        e = '{16'sd692, 1'b0, 14};     run(16'sd256, 4'd4, 2'b00, 1, e);

        // Reset in the middle of ACC takes effect without a clock edge.
        launch_to_second_cmul();
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("mrst_ready", ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_result", result, 0);
        chk("mrst_ovf", ovf, 0);
        chk("mrst_coef_addr", coef_addr, 0);
        @(negedge clk) rst = 1'b0;
        e = '{16'sd692, 1'b0, 16};     run(16'sd256, 4'd4, 2'b00, 3, e);

        // Randomised operands against the arithmetic model.
        for (int i = 0; i < 8; i++) begin
            int xr, nr, mr, hr;
            xr = int'($urandom_range(0, 1023)) - 512;
            nr = int'($urandom_range(0, 10));
            mr = int'($urandom_range(0, 3));
            hr = int'($urandom_range(1, 3));
            model(xr, nr, mr, hr, e);
            run(16'(xr), 4'(nr), 2'(mr), hr, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
